// File: rtl/axis_pkt_arbiter_pkg.sv
// Shared types and helpers for the packet-atomic AXI4-Stream arbiter.
// Holds the FSM state type, default widths and the round-robin pick function.
package axis_arb_pkg;

    typedef enum logic [0:0] {ARB_IDLE, ARB_XFER} arb_state_t;

    localparam int unsigned AXIS_DATA_W = 32;
    localparam int unsigned AXIS_NUM_SI = 3;

    // The selector always works on 8 lanes; unused upper lanes never request.
    localparam int unsigned RR_W     = 8;
    localparam int unsigned RR_IDX_W = 3;

    // First requester strictly after `last`, wrapping; one-hot result, 0 if none.
    function automatic logic [RR_W-1:0] rr_pick(input logic [RR_W-1:0]     req,
                                                input logic [RR_IDX_W-1:0] last);
        logic [RR_W-1:0]     gnt;
        logic [RR_IDX_W-1:0] idx;
        gnt = '0;
        for (int k = 1; k <= int'(RR_W); k++) begin
            idx = last + RR_IDX_W'(k);
            if (gnt == '0 && req[idx]) begin
                gnt[idx] = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/axis_pkt_arbiter_if.sv
// Stream bundle for axis_pkt_arbiter: NUM_SI slave streams in, one master stream out.
// The arbiter connects through the slave modport; the traffic environment uses master.
interface axis_pkt_arbiter_if
    import axis_arb_pkg::*;
#(
    parameter int unsigned NUM_SI = AXIS_NUM_SI,
    parameter int unsigned DATA_W = AXIS_DATA_W
);

    logic [NUM_SI-1:0]          s_axis_tvalid;
    logic [NUM_SI-1:0]          s_axis_tready;
    logic [NUM_SI*DATA_W-1:0]   s_axis_tdata;
    logic [NUM_SI*DATA_W/8-1:0] s_axis_tkeep;
    logic [NUM_SI-1:0]          s_axis_tlast;
    logic [NUM_SI-1:0]          s_req_suppress;

    logic                       m_axis_tvalid;
    logic                       m_axis_tready;
    logic [DATA_W-1:0]          m_axis_tdata;
    logic [DATA_W/8-1:0]        m_axis_tkeep;
    logic                       m_axis_tlast;

    modport slave (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_req_suppress,
        input  m_axis_tready,
        output s_axis_tready,
        output m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
    );

    modport master (
        output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_req_suppress,
        output m_axis_tready,
        input  s_axis_tready,
        input  m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
    );

endinterface

// File: rtl/axis_rr_sel.sv
// Combinational round-robin selector: one-hot grant of the first requester after `last`.
module axis_rr_sel
    import axis_arb_pkg::*;
#(
    parameter int unsigned NUM_SI = AXIS_NUM_SI
) (
    input  logic [NUM_SI-1:0]   req_i,
    input  logic [RR_IDX_W-1:0] last_i,
    output logic [NUM_SI-1:0]   gnt_o,
    output logic                valid_o
);

    logic [RR_W-1:0] pick;

    assign pick    = rr_pick(RR_W'(req_i), last_i);
    assign gnt_o   = pick[NUM_SI-1:0];
    assign valid_o = |pick;

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-atomic round-robin arbiter: NUM_SI AXI4-Stream sources onto one registered master.
// Optional per-source completed-packet counters when AXIS_ARB_PKT_CNT_EN is defined.
module axis_pkt_arbiter
    import axis_arb_pkg::*;
#(
    parameter int unsigned NUM_SI = AXIS_NUM_SI,
    parameter int unsigned DATA_W = AXIS_DATA_W
`ifdef AXIS_ARB_PKT_CNT_EN
    ,
    parameter int unsigned CNT_W  = 16
`endif
) (
    input  logic                     aclk,
    input  logic                     areset,
    axis_pkt_arbiter_if.slave        bus,
    output logic [NUM_SI-1:0]        grant,
    output logic                     busy
`ifdef AXIS_ARB_PKT_CNT_EN
    ,
    output logic [NUM_SI*CNT_W-1:0]  pkt_cnt
`endif
);

    localparam int unsigned KEEP_W = DATA_W / 8;

    arb_state_t            state_q, state_d;
    logic [NUM_SI-1:0]     grant_q, grant_d;
    logic [RR_IDX_W-1:0]   last_q, last_d;

    logic [NUM_SI-1:0]     eligible;
    logic [NUM_SI-1:0]     sel_gnt;
    logic                  sel_valid;
    logic [RR_IDX_W-1:0]   sel_idx;

    logic [NUM_SI-1:0]     tready;
    logic                  src_valid;
    logic                  src_last;
    logic [DATA_W-1:0]     src_data;
    logic [KEEP_W-1:0]     src_keep;
    logic                  out_free;
    logic                  accept;

    logic                  m_valid_q;
    logic                  m_last_q;
    logic [DATA_W-1:0]     m_data_q;
    logic [KEEP_W-1:0]     m_keep_q;

    // Suppress only matters when choosing a new owner.
    assign eligible = bus.s_axis_tvalid & ~bus.s_req_suppress;

    axis_rr_sel #(
        .NUM_SI (NUM_SI)
    ) u_rr_sel (
        .req_i   (eligible),
        .last_i  (last_q),
        .gnt_o   (sel_gnt),
        .valid_o (sel_valid)
    );

    always_comb begin
        sel_idx = '0;
        for (int unsigned i = 0; i < NUM_SI; i++) begin
            if (sel_gnt[i]) sel_idx = RR_IDX_W'(i);
        end
    end

    always_comb begin
        src_valid = 1'b0;
        src_last  = 1'b0;
        src_data  = '0;
        src_keep  = '0;
        for (int unsigned i = 0; i < NUM_SI; i++) begin
            if (grant_q[i]) begin
                src_valid = bus.s_axis_tvalid[i];
                src_last  = bus.s_axis_tlast[i];
                src_data  = bus.s_axis_tdata[i*DATA_W +: DATA_W];
                src_keep  = bus.s_axis_tkeep[i*KEEP_W +: KEEP_W];
            end
        end
    end

    assign out_free = !m_valid_q || bus.m_axis_tready;
    assign accept   = (state_q == ARB_XFER) && src_valid && out_free;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        tready  = '0;
        unique case (state_q)
            ARB_IDLE: begin
                if (sel_valid) begin
                    grant_d = sel_gnt;
                    last_d  = sel_idx;
                    state_d = ARB_XFER;
                end
            end
            ARB_XFER: begin
                tready = out_free ? grant_q : '0;
                if (accept && src_last) begin
                    grant_d = '0;
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            last_q  <= RR_IDX_W'(NUM_SI - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Output register drains on its own, independent of the FSM.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
            m_keep_q  <= '0;
        end else if (accept) begin
            m_valid_q <= 1'b1;
            m_last_q  <= src_last;
            m_data_q  <= src_data;
            m_keep_q  <= src_keep;
        end else if (bus.m_axis_tready) begin
            m_valid_q <= 1'b0;
        end
    end

`ifdef AXIS_ARB_PKT_CNT_EN
    logic [NUM_SI-1:0][CNT_W-1:0] cnt_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_SI; i++) begin
                if (accept && src_last && grant_q[i]) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
        end
    end

    assign pkt_cnt = cnt_q;
`endif

    assign bus.s_axis_tready = tready;
    assign bus.m_axis_tvalid = m_valid_q;
    assign bus.m_axis_tlast  = m_last_q;
    assign bus.m_axis_tdata  = m_data_q;
    assign bus.m_axis_tkeep  = m_keep_q;
    assign grant             = grant_q;
    assign busy              = (state_q == ARB_XFER) || m_valid_q;

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Self-checking bench for axis_pkt_arbiter: queue-driven sources, per-cycle model compare,
// and directed scenario checks. Define AXIS_ARB_PKT_CNT_EN to also cover the counters.
module tb_axis_pkt_arbiter;
    import axis_arb_pkg::*;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int KW = DW / 8;
`ifdef AXIS_ARB_PKT_CNT_EN
    localparam int CW = 4;
`endif

    logic         aclk = 1'b0;
    logic         areset = 1'b1;
    logic [N-1:0] grant;
    logic         busy;
`ifdef AXIS_ARB_PKT_CNT_EN
    logic [N*CW-1:0] pkt_cnt;
`endif

    axis_pkt_arbiter_if #(.NUM_SI(N), .DATA_W(DW)) bus ();

    axis_pkt_arbiter #(
        .NUM_SI (N),
        .DATA_W (DW)
`ifdef AXIS_ARB_PKT_CNT_EN
        ,
        .CNT_W  (CW)
`endif
    ) dut (
        .aclk    (aclk),
        .areset  (areset),
        .bus     (bus),
        .grant   (grant),
        .busy    (busy)
`ifdef AXIS_ARB_PKT_CNT_EN
        ,
        .pkt_cnt (pkt_cnt)
`endif
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        bit            l;
    } beat_t;

    typedef struct {
        logic [DW-1:0] d;
        bit            l;
        int            cyc;
    } obs_t;

    beat_t        srcq [N][$];
    obs_t         mlog[$];
    logic [N-1:0] glog[$];
    logic [N-1:0] prev_g;
    logic [N-1:0] acc_mask;
    int           cyc;
    int           n_chk;
    int           n_fail;

    // Reference model state: owner index (-1 idle), rr pointer, output register, counters.
    int            m_own;
    int            m_last;
    bit            m_ov;
    logic [DW-1:0] m_od;
    logic [KW-1:0] m_ok;
    bit            m_ol;
    int            m_cnt [N];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic present();
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0) begin
                bus.s_axis_tvalid[i]            = 1'b1;
                bus.s_axis_tdata[i*DW +: DW]    = srcq[i][0].d;
                bus.s_axis_tkeep[i*KW +: KW]    = srcq[i][0].k;
                bus.s_axis_tlast[i]             = srcq[i][0].l;
            end else begin
                bus.s_axis_tvalid[i]            = 1'b0;
                bus.s_axis_tdata[i*DW +: DW]    = '0;
                bus.s_axis_tkeep[i*KW +: KW]    = '0;
                bus.s_axis_tlast[i]             = 1'b0;
            end
        end
    endtask

    task automatic push_beat(input int src, input logic [DW-1:0] d, input bit l);
        beat_t b;
        b.d = d;
        b.k = KW'(d[3:0] | 4'h1);
        b.l = l;
        srcq[src].push_back(b);
    endtask

    task automatic push_pkt(input int src, input int len, input logic [7:0] tag);
        for (int j = 0; j < len; j++) push_beat(src, {tag, 16'h0, 8'(j)}, j == len - 1);
    endtask

    task automatic model_reset();
        m_own  = -1;
        m_last = N - 1;
        m_ov   = 0;
        m_od   = '0;
        m_ok   = '0;
        m_ol   = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] elig;
        bit           free;
        bit           take;
        bit           found;
        free = !m_ov || bus.m_axis_tready;
        take = (m_own >= 0) && free && bus.s_axis_tvalid[m_own];
        if (m_own < 0) begin
            elig  = bus.s_axis_tvalid & ~bus.s_req_suppress;
            found = 0;
            for (int k = 1; k <= N; k++) begin
                if (!found && elig[(m_last + k) % N]) begin
                    found  = 1;
                    m_own  = (m_last + k) % N;
                    m_last = m_own;
                end
            end
            if (bus.m_axis_tready) m_ov = 0;
        end else if (take) begin
            m_ov = 1;
            m_od = bus.s_axis_tdata[m_own*DW +: DW];
            m_ok = bus.s_axis_tkeep[m_own*KW +: KW];
            m_ol = bus.s_axis_tlast[m_own];
            if (m_ol) begin
`ifdef AXIS_ARB_PKT_CNT_EN
                m_cnt[m_own] = (m_cnt[m_own] + 1) % (1 << CW);
`endif
                m_own = -1;
            end
        end else if (bus.m_axis_tready) begin
            m_ov = 0;
        end
    endtask

    // Compare process: check outputs against the model every cycle, then advance the model.
    initial begin
        cyc    = 0;
        prev_g = '0;
        model_reset();
        forever begin
            logic [N-1:0] eg;
            logic [N-1:0] et;
            @(negedge aclk);
            cyc++;
            if (areset) model_reset();
            eg = '0;
            et = '0;
            if (m_own >= 0) begin
                eg[m_own] = 1'b1;
                if (!m_ov || bus.m_axis_tready) et[m_own] = 1'b1;
            end
            chk("grant", grant, eg);
            chk("s_tready", bus.s_axis_tready, et);
            chk("busy", busy, (m_own >= 0) || m_ov);
            chk("m_tvalid", bus.m_axis_tvalid, m_ov);
            if (m_ov) begin
                chk("m_tdata", bus.m_axis_tdata, m_od);
                chk("m_tkeep", bus.m_axis_tkeep, m_ok);
                chk("m_tlast", bus.m_axis_tlast, m_ol);
            end
`ifdef AXIS_ARB_PKT_CNT_EN
            for (int i = 0; i < N; i++) chk("pkt_cnt", pkt_cnt[i*CW +: CW], 64'(m_cnt[i]));
`endif
            acc_mask = bus.s_axis_tvalid & bus.s_axis_tready;
            if (bus.m_axis_tvalid && bus.m_axis_tready)
                mlog.push_back('{d: bus.m_axis_tdata, l: bus.m_axis_tlast, cyc: cyc});
            if (grant != prev_g) glog.push_back(grant);
            prev_g = grant;
            if (!areset) model_step();
        end
    end

    // Source driver: retire beats the DUT accepted, then present the next queue heads.
    initial begin
        forever begin
            @(posedge aclk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc_mask[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
            end
            present();
        end
    end

    task automatic tick();
        @(posedge aclk);
        #2;
    endtask

    task automatic clear_logs();
        mlog.delete();
        glog.delete();
    endtask

    task automatic wait_src(input int src, input int keep_left, input string nm);
        int t = 0;
        while (srcq[src].size() > keep_left && t < 200) begin
            tick();
            t++;
        end
        if (t >= 200) chk(nm, 64'(srcq[src].size()), 64'(keep_left));
    endtask

    task automatic wait_all(input string nm);
        for (int i = 0; i < N; i++) wait_src(i, 0, nm);
        repeat (3) tick();
    endtask

    task automatic check_glog(input string nm, input logic [N-1:0] exp[$]);
        chk({nm, "_len"}, 64'(glog.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < glog.size(); i++) chk(nm, glog[i], exp[i]);
    endtask

    initial begin
        logic [N-1:0] eg[$];
        logic [7:0]   etag[$];
        n_chk  = 0;
        n_fail = 0;
        acc_mask = '0;
        bus.m_axis_tready   = 1'b0;
        bus.s_req_suppress  = '0;
        present();
        repeat (3) tick();

        // Reset values.
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_m_tvalid", bus.m_axis_tvalid, 0);
        chk("rst_m_tdata", bus.m_axis_tdata, 0);
        chk("rst_m_tkeep", bus.m_axis_tkeep, 0);
        chk("rst_s_tready", bus.s_axis_tready, 0);
        areset = 1'b0;
        tick();

        // Two 4-beat packets competing: source 0 first, one idle cycle, then source 1.
        clear_logs();
        bus.m_axis_tready = 1'b1;
        push_pkt(0, 4, 8'hA0);
        push_pkt(1, 4, 8'hB1);
        present();
        wait_all("t1_timeout");
        chk("t1_beats", 64'(mlog.size()), 8);
        for (int j = 0; j < 8 && j < mlog.size(); j++) begin
            chk("t1_data", mlog[j].d, {(j < 4) ? 8'hA0 : 8'hB1, 16'h0, 8'(j % 4)});
            chk("t1_last", mlog[j].l, (j % 4) == 3);
        end
        if (mlog.size() == 8) begin
            chk("t1_intra_gap", 64'(mlog[1].cyc - mlog[0].cyc), 1);
            chk("t1_rearb_gap", 64'(mlog[4].cyc - mlog[3].cyc), 2);
        end
        eg = '{3'b001, 3'b000, 3'b010, 3'b000};
        check_glog("t1_grant_seq", eg);

        // Suppress 0 and 2: only source 1 runs; after release, rr continues with 2 then 0.
        clear_logs();
        bus.s_req_suppress = 3'b101;
        push_pkt(0, 2, 8'hC0);
        push_pkt(1, 2, 8'hC1);
        push_pkt(2, 2, 8'hC2);
        present();
        wait_src(1, 0, "t2_timeout");
        bus.s_req_suppress = 3'b000;
        wait_all("t2_timeout");
        eg = '{3'b010, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000};
        check_glog("t2_grant_seq", eg);
        etag = '{8'hC1, 8'hC1, 8'hC2, 8'hC2, 8'hC0, 8'hC0};
        chk("t2_beats", 64'(mlog.size()), 6);
        for (int j = 0; j < 6 && j < mlog.size(); j++) chk("t2_src_order", mlog[j].d[31:24], etag[j]);

        // Back-pressure on source 2: A,B,C must come out intact and hold while stalled.
        clear_logs();
        push_beat(2, 32'hAAAA_0001, 0);
        push_beat(2, 32'hBBBB_0002, 0);
        push_beat(2, 32'hCCCC_0003, 1);
        present();
        begin
            int t = 0;
            while (!bus.m_axis_tvalid && t < 20) begin
                tick();
                t++;
            end
            chk("t3_first_beat", bus.m_axis_tdata, 32'hAAAA_0001);
        end
        begin
            logic p [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
            for (int s = 0; s < 4; s++) begin
                bus.m_axis_tready = p[s];
                tick();
                if (s < 3) chk("t3_stall_data", bus.m_axis_tdata, 32'hBBBB_0002);
            end
        end
        bus.m_axis_tready = 1'b1;
        wait_all("t3_timeout");
        chk("t3_beats", 64'(mlog.size()), 3);
        if (mlog.size() == 3) begin
            chk("t3_a", mlog[0].d, 32'hAAAA_0001);
            chk("t3_b", mlog[1].d, 32'hBBBB_0002);
            chk("t3_c", mlog[2].d, 32'hCCCC_0003);
            chk("t3_c_last", mlog[2].l, 1);
        end

        // Suppress mid-packet does not cut the owner's packet short.
        clear_logs();
        push_pkt(0, 5, 8'hD0);
        push_pkt(1, 2, 8'hD1);
        push_pkt(2, 2, 8'hD2);
        present();
        wait_src(0, 3, "t4_timeout");
        bus.s_req_suppress = 3'b001;
        wait_all("t4_timeout");
        bus.s_req_suppress = 3'b000;
        etag = '{8'hD0, 8'hD0, 8'hD0, 8'hD0, 8'hD0, 8'hD1, 8'hD1, 8'hD2, 8'hD2};
        chk("t4_beats", 64'(mlog.size()), 9);
        for (int j = 0; j < 9 && j < mlog.size(); j++) chk("t4_src_order", mlog[j].d[31:24], etag[j]);

        // Reset in the middle of a packet, then source 0 has first priority again.
        clear_logs();
        push_pkt(0, 4, 8'hE0);
        present();
        wait_src(0, 2, "t5_timeout");
        areset = 1'b1;
        @(negedge aclk);
        chk("t5_rst_m_tvalid", bus.m_axis_tvalid, 0);
        chk("t5_rst_grant", grant, 0);
        chk("t5_rst_busy", busy, 0);
        for (int i = 0; i < N; i++) srcq[i].delete();
        present();
        tick();
        areset = 1'b0;
        tick();
        clear_logs();
        push_pkt(1, 2, 8'hF1);
        push_pkt(0, 2, 8'hF0);
        present();
        wait_all("t5_timeout");
        eg = '{3'b001, 3'b000, 3'b010, 3'b000};
        check_glog("t5_grant_seq", eg);

`ifdef AXIS_ARB_PKT_CNT_EN
        // 17 packets from source 1 wrap its 4-bit counter to 1.
        areset = 1'b1;
        tick();
        areset = 1'b0;
        tick();
        for (int p = 0; p < 17; p++) push_pkt(1, 1, 8'h71);
        present();
        wait_all("t6_timeout");
        chk("t6_cnt0", pkt_cnt[0 +: CW], 0);
        chk("t6_cnt1", pkt_cnt[CW +: CW], 1);
        chk("t6_cnt2", pkt_cnt[2*CW +: CW], 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/axis_pkt_arbiter.md
# axis_pkt_arbiter

Packet-atomic round-robin arbiter that shares one 32-bit AXI4-Stream master among three slave streams. It sits in front of the quabo output stream path and replaces free-running switch arbitration. It guarantees that a granted source keeps the output until its `tlast` beat is accepted. A per-source suppress mask removes sources from arbitration without breaking packets that are already in flight.

## Interface
- `NUM_SI`, 3: number of slave streams, 2..8
- `DATA_W`, 32: tdata width in bits; tkeep width is `DATA_W/8`
- `CNT_W`, 16: width of each per-source packet counter (only with the `_EN` macro)
- `aclk` in 1: single clock; all logic is rising-edge
- `areset` in 1: asynchronous, active-high reset
- `s_axis_tvalid` in NUM_SI: per-source valid
- `s_axis_tready` out NUM_SI: per-source ready
- `s_axis_tdata` in NUM_SI*DATA_W: source i occupies bits [i*DATA_W +: DATA_W]
- `s_axis_tkeep` in NUM_SI*DATA_W/8: packed the same way as tdata
- `s_axis_tlast` in NUM_SI: per-source last
- `s_req_suppress` in NUM_SI: 1 excludes the source from new grants
- `m_axis_tvalid`, `m_axis_tdata`, `m_axis_tkeep`, `m_axis_tlast` out 1/DATA_W/DATA_W/8/1: registered master stream
- `m_axis_tready` in 1: master ready
- `grant` out NUM_SI: one-hot current owner; 0 when idle
- `busy` out 1: a packet is in progress
- `pkt_cnt` out NUM_SI*CNT_W: per-source completed-packet counts (only with the `_EN` macro)

## Operation
- FSM has two states, IDLE and XFER.
- Eligible mask: `s_axis_tvalid & ~s_req_suppress`.
- IDLE:
  - If the eligible mask is nonzero, select the first eligible source scanning from `last+1` mod NUM_SI upward with wrap-around.
  - Register the selection into `grant`, set `last` to it, and go to XFER.
  - No beat is accepted in the cycle the grant is decided.
- XFER:
  - `s_axis_tready[g] = !m_axis_tvalid || m_axis_tready`. All other tready bits are 0.
  - Each accepted beat is loaded into the output register.
  - When a beat with tlast=1 is accepted, go to IDLE and clear `grant`.
  - The output register drains independently of the FSM.
- `s_req_suppress` is sampled only in IDLE. Asserting it mid-packet does not stop the current owner.
- Output register:
  - Load on `s_axis_tvalid[g] & s_axis_tready[g]`.
  - Clear `m_axis_tvalid` on `m_axis_tready` when no new load happens.
  - Payload bits are held while valid and not ready.
- Round-robin pointer `last` resets to NUM_SI-1, so source 0 has first priority.
- If a source drops tvalid mid-packet, the grant is held indefinitely. There is no timeout.

## Timing
- Reset values:
  - `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `m_axis_tkeep`=0.
  - `s_axis_tready`=0, `grant`=0, `busy`=0, `pkt_cnt`=0.
  - FSM=IDLE, `last`=NUM_SI-1.
- Latency:
  - Request to first tready: 1 cycle (the IDLE decide cycle).
  - Slave beat to master beat: 1 cycle.
- Throughput:
  - 1 beat/cycle inside a packet.
  - 1 idle cycle between packets for re-arbitration, so a single-beat packet costs 2 cycles.
- Tlast accepted while `m_axis_tready`=0: the FSM still returns to IDLE. The next grant can be decided while the output register is full, but the new owner's tready stays 0 until the register drains.
- Reset asserted mid-packet: all state clears immediately, any in-flight beat is dropped, and the master sees `tvalid` fall asynchronously.
- `busy` = (FSM==XFER) || `m_axis_tvalid`.

## Configuration
- `AXIS_ARB_PKT_CNT_EN` defined:
  - One CNT_W-bit counter per source increments on each accepted tlast beat from that source.
  - Counters wrap at 2^CNT_W-1 to 0 and are cleared only by reset.
  - The `pkt_cnt` port exists.
- Not defined: no counters, and `pkt_cnt` is absent from the port list.

## Structure
- Shared package `axis_arb_pkg` holds:
  - FSM state enum `arb_state_t` {ARB_IDLE, ARB_XFER}.
  - Defaults `AXIS_DATA_W`=32, `AXIS_NUM_SI`=3.
  - Function `rr_pick(req, last)` returning a one-hot grant.
- One sub-module, `axis_rr_sel`: purely combinational round-robin selector (req, last → one-hot, valid). It is instantiated once.
- The top holds the FSM, the output register and the optional counters.

## Test plan
- Reset, then `s_axis_tvalid`=3'b011, 4-beat packets on sources 0 and 1, `m_axis_tready`=1 → source 0's 4 beats, 1 idle cycle, then source 1's 4 beats. `grant` goes 001 → 000 → 010.
- `s_req_suppress`=3'b101, all sources valid → only source 1 is ever granted. Release suppress after source 1's tlast → next grant is source 2, then source 0.
- Source 2 granted, `m_axis_tready` toggling 1,0,0,1 during a 3-beat packet with data A,B,C → master emits A,B,C in order with no loss or duplication, and data is stable while tready=0.
- Assert `s_req_suppress[0]` on beat 2 of a 5-beat source 0 packet → all 5 beats complete before any other grant.
- Assert `areset` on beat 2 of a packet → the next cycle shows `m_axis_tvalid`=0, `grant`=0, `busy`=0. After release, source 0 again has first priority.
- With `AXIS_ARB_PKT_CNT_EN`, CNT_W=4, 17 packets from source 1 → `pkt_cnt[1]`=1 (wrapped) and the other counters are 0.
